// File: rtl/row_adc_sequencer.sv
// Row conversion sequencer for the single-slope column ADC: reset pulse, ramp window, shadow snapshot, pixel readout.
// Latency: start sampled at edge 0 -> adc_reset cycles 1..RST_CYCLES, ramp_en next RAMP_CYCLES cycles, first word in the cycle after the snapshot.
// Backpressure: readout stalls while out_ready is low, with every out_* field held stable. Optional ROW_SEQ_FRAME_CNT_EN adds the frame_cnt output.
module row_adc_sequencer #(
  parameter int NUM_PIXELS  = 5,
  parameter int RST_CYCLES  = 4,
  parameter int RAMP_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    adc_reset,
  output logic                    ramp_en,
  input  logic [NUM_PIXELS*8-1:0] stored_values,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic [5:0]              out_pix,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
`ifdef ROW_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARST = 3'd1,
    RAMP = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] RST_LOAD  = 8'(RST_CYCLES - 1);
  localparam logic [7:0] RAMP_LOAD = 8'(RAMP_CYCLES - 1);
  localparam logic [5:0] LAST_IDX  = 6'(NUM_PIXELS - 1);

  state_t                  state_q, state_d;
  logic [7:0]              phase_q, phase_d;
  logic [5:0]              idx_q, idx_d;
  logic [NUM_PIXELS*8-1:0] shadow_q;
  logic [NUM_PIXELS*8-1:0] shadow_src;
  logic [7:0]              data_d;
  logic                    snap;
  logic                    fire;

  assign fire = out_valid && out_ready;

  // Next-state, phase counter, pixel index and snapshot decision.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    snap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARST;
          phase_d = RST_LOAD;
        end
      end
      ARST: begin
        if (phase_q == 8'd0) begin
          state_d = RAMP;
          phase_d = RAMP_LOAD;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      RAMP: begin
        if (phase_q == 8'd0) begin
          snap    = 1'b1;
          idx_d   = 6'd0;
          state_d = READ;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      READ: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word for the next cycle comes from the fresh capture on the snapshot edge, otherwise from the shadow.
  always_comb begin
    shadow_src = snap ? stored_values : shadow_q;
    data_d     = shadow_src[8*int'(idx_d) +: 8];
  end

  // State, counters and shadow array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= 8'd0;
      idx_q    <= 6'd0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      if (snap) begin
        shadow_q <= stored_values;
      end
    end
  end

  // All outputs are registered images of the upcoming state so they change exactly on state boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_reset <= 1'b0;
      ramp_en   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_pix   <= 6'd0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      adc_reset <= (state_d == ARST);
      ramp_en   <= (state_d == RAMP);
      out_valid <= (state_d == READ);
      out_data  <= (state_d == READ) ? data_d : 8'd0;
      out_pix   <= (state_d == READ) ? idx_d : 6'd0;
      out_last  <= (state_d == READ) && (idx_d == LAST_IDX);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
    end
  end

`ifdef ROW_SEQ_FRAME_CNT_EN
  // Completed-row counter, bumped as the DONE cycle ends; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= 16'd0;
    end else if (state_q == DONE) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_row_adc_sequencer.sv
// Bench for row_adc_sequencer: a time-based reference model predicts every output each cycle.
// Directed runs pin the model with literal cycle numbers and codes; later runs randomize start, ready and capture data.
// Sampling happens on the falling edge; inputs change only there.
module tb_row_adc_sequencer;

  localparam int N = 5;
  localparam int R = 4;
  localparam int P = 256;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           adc_reset;
  logic           ramp_en;
  logic [N*8-1:0] sv;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_data;
  logic [5:0]     out_pix;
  logic           out_last;
  logic           busy;
  logic           done;
`ifdef ROW_SEQ_FRAME_CNT_EN
  logic [15:0]    frame_cnt;
`endif

  row_adc_sequencer #(.NUM_PIXELS(N), .RST_CYCLES(R), .RAMP_CYCLES(P)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .adc_reset(adc_reset),
    .ramp_en(ramp_en),
    .stored_values(sv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_pix(out_pix),
    .out_last(out_last),
    .busy(busy),
    .done(done)
`ifdef ROW_SEQ_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  // Model: m_age = cycles since the accepted start edge; m_k = words accepted so far.
  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_k = 0;
  logic [7:0]  m_snap [N];
  logic [15:0] m_frames = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit e_arst();
    return m_busy && m_age >= 1 && m_age <= R;
  endfunction
  function automatic bit e_ramp();
    return m_busy && m_age > R && m_age <= R + P;
  endfunction
  function automatic bit e_valid();
    return m_busy && m_age > R + P && m_k < N;
  endfunction
  function automatic bit e_done();
    return m_busy && m_age > R + P && m_k == N;
  endfunction

  task automatic compare_cycle();
    bit ev;
    ev = e_valid();
    chk("adc_reset", {31'd0, adc_reset}, {31'd0, e_arst()});
    chk("ramp_en", {31'd0, ramp_en}, {31'd0, e_ramp()});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, e_done()});
    if (ev) begin
      chk("out_data", {24'd0, out_data}, {24'd0, m_snap[m_k]});
      chk("out_pix", {26'd0, out_pix}, m_k);
      chk("out_last", {31'd0, out_last}, {31'd0, m_k == N - 1});
    end else if (!m_busy) begin
      chk("idle_data", {24'd0, out_data}, 32'd0);
      chk("idle_pix", {26'd0, out_pix}, 32'd0);
      chk("idle_last", {31'd0, out_last}, 32'd0);
    end
`ifdef ROW_SEQ_FRAME_CNT_EN
    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_frames});
`endif
    if (done === 1'b1) done_seen++;
  endtask

  // Advance the model across the coming rising edge using the inputs just driven.
  task automatic step_model();
    bit v, d;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_k    = 0;
      end
    end else begin
      v = e_valid();
      d = e_done();
      if (m_age == R + P)
        for (int i = 0; i < N; i++) m_snap[i] = sv[8*i +: 8];
      if (v && out_ready) m_k++;
      if (d) begin
        m_busy   = 1'b0;
        m_frames = m_frames + 16'd1;
      end
      m_age++;
    end
  endtask

  task automatic rand_sv();
    for (int i = 0; i < N; i++) sv[8*i +: 8] = 8'($urandom_range(0, 255));
  endtask

  // mode 0: single start, ready=1, fixed codes until snapshot, literal pins
  // mode 1: single start, ready pattern 1,0,0,1 during readout
  // mode 2: single start plus stray starts while busy
  // mode 3: fully random
  // mode 4: start held high for three conversions
  task automatic run(input int n, input int mode);
    bit [3:0] pat;
    int j;
    pat = 4'b1001;
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      compare_cycle();
      if (mode == 0) begin
        case (cyc)
          4:   chk("lit_arst_c4", {31'd0, adc_reset}, 32'd1);
          5:   chk("lit_ramp_c5", {30'd0, ramp_en, adc_reset}, 32'd2);
          260: chk("lit_ramp_c260", {31'd0, ramp_en}, 32'd1);
          261: chk("lit_word0", {15'd0, out_valid, out_last, out_pix, out_data}, {15'd0, 1'b1, 1'b0, 6'd0, 8'd10});
          262: chk("lit_word1", {24'd0, out_data}, 32'd0);
          263: chk("lit_word2", {24'd0, out_data}, 32'd255);
          264: chk("lit_word3", {24'd0, out_data}, 32'd128);
          265: chk("lit_word4", {15'd0, out_valid, out_last, out_pix, out_data}, {15'd0, 1'b1, 1'b1, 6'd4, 8'd77});
          266: chk("lit_done_c266", {30'd0, done, out_valid}, 32'd2);
          267: chk("lit_busy_c267", {30'd0, busy, done}, 32'd0);
          default: ;
        endcase
      end
      case (mode)
        0, 1: start = (cyc == 0);
        2:    start = (cyc == 0) || (m_busy && $urandom_range(0, 2) == 0);
        3:    start = ($urandom_range(0, 15) == 0);
        default: start = (cyc < 2 * 268 + 10);
      endcase
      if (mode == 3) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else if (mode == 1 && e_valid()) begin
        j = (m_age - R - P - 1) % 4;
        out_ready = pat[3 - j];
      end else begin
        out_ready = 1'b1;
      end
      if (mode == 0) begin
        if (m_busy && m_age > R + P) rand_sv();
      end else begin
        rand_sv();
      end
      step_model();
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_age    = 0;
    m_k      = 0;
    m_frames = 16'd0;
    for (int i = 0; i < N; i++) m_snap[i] = 8'd0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    sv        = {8'd77, 8'd128, 8'd255, 8'd0, 8'd10};
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_outputs", {16'd0, adc_reset, ramp_en, out_valid, out_last, busy, done, out_pix, 2'b00, 2'b00}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    reset = 1'b0;

    // Nominal conversion with the flip-count codes 10,0,255,128,77.
    sv = {8'd77, 8'd128, 8'd255, 8'd0, 8'd10};
    run(275, 0);

    // Stalled readout.
    run(275, 1);

    // Stray starts while busy: exactly one done.
    done_seen = 0;
    run(280, 2);
    chk("one_done_stray_start", done_seen, 32'd1);

    // Reset in cycle 100 (mid-ramp): outputs clear at once, no done.
    done_seen = 0;
    sv = {8'd77, 8'd128, 8'd255, 8'd0, 8'd10};
    run(100, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_outputs", {16'd0, adc_reset, ramp_en, out_valid, out_last, busy, done, out_pix, 4'd0}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_no_done", done_seen, 32'd0);
    sv = {8'd77, 8'd128, 8'd255, 8'd0, 8'd10};
    run(275, 0);

    // Start held high: three back-to-back conversions.
    done_seen = 0;
    run(3 * 268 + 10, 4);
    chk("three_dones", done_seen, 32'd3);

    // Random traffic.
    run(3000, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/row_adc_sequencer.md
# row_adc_sequencer

Conversion sequencer for one row of the single-slope column ADC. On a start request it pulses the ADC's local reset, enables the ramp for a programmed number of clocks and snapshots the per-pixel 8-bit codes. It then streams the codes out one pixel per beat over a valid/ready handshake to the row readout path. It sits between the frame-level controller (start/done) and the row ADC plus ramp generator.

## Interface
- NUM_PIXELS, 5, pixels per row; range 1–64.
- RST_CYCLES, 4, width of `adc_reset` pulse in clocks; range 1–15.
- RAMP_CYCLES, 256, clocks `ramp_en` stays high; range 1–256.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; clock clk.
- start  in  1  conversion request; sampled only in IDLE.
- adc_reset  out  1  drives the row ADC reset; clears its counter and edge state.
- ramp_en  out  1  ramp DAC enable.
- stored_values  in  NUM_PIXELS×8  ADC capture registers, pixel i at bits [8i+7:8i].
- out_valid  out  1  readout word valid.
- out_ready  in  1  downstream accepts a word.
- out_data  out  8  pixel code.
- out_pix  out  6  pixel index of `out_data`.
- out_last  out  1  marks pixel NUM_PIXELS-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, ARST, RAMP, READ, DONE. All outputs come from registers.
- IDLE: all outputs are 0. If `start`=1 at an edge, go to ARST and load the phase counter with RST_CYCLES-1.
- ARST: `adc_reset`=1. The phase counter decrements each clock. At 0, go to RAMP and load RAMP_CYCLES-1.
- RAMP: `ramp_en`=1. The phase counter is 8 bits and decrements. At 0:
  - Snapshot all of `stored_values` into an internal shadow array on the same edge.
  - Clear the pixel index.
  - Go to READ.
- READ:
  - `out_valid`=1, `out_data`=shadow[idx], `out_pix`=idx, `out_last`=(idx==NUM_PIXELS-1).
  - On `out_valid && out_ready`, idx increments.
  - On the last beat's handshake, go to DONE.
  - While `out_ready`=0, all out_* fields hold stable.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` in any state other than IDLE is ignored. It is not queued.
- The shadow snapshot isolates readout from later ADC counter wrap and comparator activity.
- Reset mid-operation: async return to IDLE. All outputs, idx, phase counter and shadow go to 0 immediately, with no `done` pulse.
- The ADC counter runs free. Releasing `adc_reset` aligns ADC count 0 with the first `ramp_en` cycle, so pixel code = ramp cycles elapsed before the comparator flip.

## Timing
- Reset values: `adc_reset`, `ramp_en`, `out_valid`, `out_data`, `out_pix`, `out_last`, `busy`, `done` all 0.
- Cycle k means the cycle following rising edge k. `start` is sampled at edge 0.
- `adc_reset` and `busy` are high from cycle 1.
- `adc_reset` is high for cycles 1..RST_CYCLES.
- `ramp_en` is high for cycles RST_CYCLES+1 .. RST_CYCLES+RAMP_CYCLES.
- The snapshot is taken at edge RST_CYCLES+RAMP_CYCLES.
- `out_valid` rises in cycle RST_CYCLES+RAMP_CYCLES+1.
- With `out_ready` tied to 1:
  - one word per cycle;
  - `done` pulses in cycle RST_CYCLES+RAMP_CYCLES+NUM_PIXELS+1;
  - `busy` falls the cycle after that.
- Minimum start-to-start period is RST_CYCLES+RAMP_CYCLES+NUM_PIXELS+2 clocks.
- `start` held high continuously re-triggers in the first IDLE cycle after DONE.

## Configuration
- `ROW_SEQ_FRAME_CNT_EN` defined:
  - adds output `frame_cnt` [15:0], reset 0;
  - increments in the DONE cycle;
  - wraps from 16'hFFFF to 0;
  - is not cleared by `start`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Defaults, pulse `start` one cycle, `out_ready`=1 -> `adc_reset` high cycles 1–4; `ramp_en` high cycles 5–260; words pix 0..4 in cycles 261–265 with `out_last` only at pix 4; `done` in cycle 266; `busy` low from cycle 267.
- ADC model with flips at ramp counts 10, 0, 255, 128, 77 -> `out_data` sequence 10, 0, 255, 128, 77. Values stay unchanged when `stored_values` is altered after the snapshot.
- `out_ready` toggled 1,0,0,1 per cycle during READ -> no word lost or duplicated; fields stable while stalled; `done` only after the pix 4 handshake.
- `start` pulsed during ARST, RAMP and READ -> ignored; exactly one conversion and one `done`.
- Assert `reset` in cycle 100 (mid-RAMP) -> all outputs 0 in the same cycle; no `done`; a new `start` gives full nominal timing.
- With `ROW_SEQ_FRAME_CNT_EN` and `start` held high for 3 conversions -> `frame_cnt` = 3; with `frame_cnt` preloaded to 16'hFFFF, one conversion -> 0.
